pwm_signal_gen: RTL and testbench
=================================

# pwm_signal_gen

On-board stimulus generator for the cymometer. It produces a programmable periodic rectangular wave on `pwm_out` with a period and high time set in `sys_clk` cycles. The output is looped back to the `clk_fx` input of the duty-cycle and pulse-width measurement path, which makes that path self-testable. New settings arrive over a valid/ready handshake and take effect only on a period boundary, so no truncated or glitched periods are emitted.

## Interface
- `DATAWIDTH`, default 30: width of period and high-time fields, in `sys_clk` cycles.
- `MIN_PERIOD`, default 2: smallest accepted period.
- `sys_clk`, in, 1: system clock (50 MHz on board).
- `sys_rst`, in, 1: reset. One clock; reset is synchronous and active-high.
- `en`, in, 1: run enable. 0 forces idle.
- `cfg_valid`, in, 1: a new configuration is offered.
- `cfg_ready`, out, 1: the block can accept a configuration.
- `cfg_period`, in, DATAWIDTH: requested period in cycles.
- `cfg_high`, in, DATAWIDTH: requested high time in cycles.
- `cfg_err`, out, 1: one-cycle pulse. Offered configuration rejected.
- `pwm_out`, out, 1: generated waveform (registered).
- `period_start`, out, 1: one-cycle pulse on the first cycle of every period.

## Operation
- Registers:
  - `act_period` and `act_high` hold the active configuration.
  - `pnd_period`, `pnd_high` and `pnd_flag` form a one-deep pending slot.
  - `cnt` is the in-period counter (DATAWIDTH bits).
  - `state` is either IDLE or RUN.
- `cfg_ready = !pnd_flag`, combinational.
- Handshake: a transfer happens on an edge where `cfg_valid && cfg_ready`.
  - If `cfg_period < MIN_PERIOD`, the transfer is consumed, `cfg_err` pulses 1 on the next cycle, and nothing is stored.
  - Otherwise the values are written to the pending slot and `pnd_flag` is set to 1.
- `cfg_valid` held while `cfg_ready = 0` is stalled, not dropped. The source holds its data until it sees ready.
- IDLE:
  - `pwm_out = 0`, `cnt = 0`.
  - Leave for RUN when `en = 1` and `pnd_flag = 1`: load pending into active, clear `pnd_flag`, `cnt <= 0`, `pwm_out <= (pnd_high != 0)`, `period_start <= 1`.
  - `act_period = 0` after reset means there is no configuration, so the block stays in IDLE.
- RUN:
  - Each edge: if `cnt == act_period - 1`, the period wraps; otherwise `cnt <= cnt + 1`.
  - Always `pwm_out <= (next_cnt < act_high)`.
  - On a wrap: `cnt <= 0` and `period_start <= 1`. If `pnd_flag` is set, load pending into active and clear `pnd_flag`; the new values govern the new period, including its first cycle.
- Duty-cycle extremes:
  - `act_high = 0` gives a constant 0.
  - `act_high >= act_period` gives a constant 1, with `period_start` still pulsing.
- `en` falling while in RUN: on the next edge go to IDLE with `pwm_out <= 0` and `cnt <= 0`. The active configuration is kept.
- `en` rising with an active configuration and no pending one: restart from `cnt = 0` with the active values.

## Timing
- Reset values: `cfg_ready = 1`, `cfg_err = 0`, `pwm_out = 0`, `period_start = 0`, state IDLE. Active and pending registers are cleared to 0 and `pnd_flag = 0`.
- Reset asserted in RUN wins over everything. It takes effect on the same edge and discards both the active and pending configuration.
- Startup latency: a transfer at edge T while in IDLE with `en = 1` gives `pnd_flag = 1` at T+1. RUN and the first high cycle start at T+2.
- A transfer on the same edge as a wrap is not applied at that wrap. It applies at the next wrap, because the wrap samples the registered `pnd_flag`.
- The output period is exactly `act_period` cycles and the high time is exactly `min(act_high, act_period)` cycles, with no off-by-one.
- Counter arithmetic is DATAWIDTH wide with no overflow: `cnt` never exceeds `act_period - 1`.

## Structure
- Package `pwm_gen_pkg` holds:
  - the state type (IDLE, RUN);
  - `MIN_PERIOD`;
  - the default `DATAWIDTH = 30`, matching the measurement path's data width.
- A single module with no sub-module. The pending-slot logic is small enough to stay inline.
- Top-level integration: `pwm_out` drives `clk_fx` in self-test builds. `cfg_*` is driven from the keypad pattern logic.

## Test plan
- Reset, then `cfg_period = 50`, `cfg_high = 25`, `en = 1` → `pwm_out` is a 1 MHz, 50 % wave: 25 cycles high, 25 low. `period_start` pulses every 50 cycles, and the first rise comes 2 cycles after the transfer.
- While running at 50/25, offer 100/10 mid-period → the current period finishes unchanged, then 10 high and 90 low. `cfg_ready` is low from the transfer until the wrap.
- `cfg_period = 1` → `cfg_err` pulses once, and the output and active configuration are unchanged. `cfg_period = 2`, `cfg_high = 1` → alternating 1,0.
- `cfg_high = 0` gives `pwm_out` constantly 0; `cfg_high = 60` with period 50 gives constantly 1. In both cases `period_start` still pulses every 50 cycles.
- Transfer on the exact wrap edge → the old values govern one more full period, and the new values start at the following wrap.
- Drop `en` mid-high, and separately assert `sys_rst` mid-period:
  - `en` drop: `pwm_out` is 0 on the next cycle; re-raising `en` restarts from a full high phase.
  - Reset: `pwm_out` is 0, and the block stays idle until it receives a new configuration.

Source files
------------

// File: rtl/pwm_gen_pkg.sv
// Shared definitions for the PWM stimulus generator.
//   pwm_state_e        : generator FSM state (IDLE / RUN)
//   DEFAULT_DATAWIDTH  : period / high-time field width, matches the
//                        measurement path's data width
//   DEFAULT_MIN_PERIOD : smallest period the generator accepts
package pwm_gen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } pwm_state_e;

  localparam int unsigned DEFAULT_DATAWIDTH  = 30;
  localparam int unsigned DEFAULT_MIN_PERIOD = 2;

endpackage

// File: rtl/pwm_signal_gen.sv
// Programmable rectangular-wave generator used as an on-board stimulus for
// the cymometer's duty-cycle / pulse-width path (pwm_out loops back to clk_fx).
// New settings arrive over a valid/ready handshake and are held in a one-deep
// pending slot.  They are applied only at a period boundary, so every emitted
// period is complete.
//
// Ports:
//   sys_clk      in   system clock
//   sys_rst      in   synchronous active-high reset
//   en           in   run enable, 0 forces idle
//   cfg_valid    in   configuration offered
//   cfg_ready    out  pending slot empty, offer can be taken
//   cfg_period   in   requested period in sys_clk cycles
//   cfg_high     in   requested high time in sys_clk cycles
//   cfg_err      out  one-cycle pulse, offered period below MIN_PERIOD
//   pwm_out      out  generated waveform (registered)
//   period_start out  one-cycle pulse on the first cycle of each period
module pwm_signal_gen
  import pwm_gen_pkg::*;
#(
  parameter int unsigned DATAWIDTH  = DEFAULT_DATAWIDTH,
  parameter int unsigned MIN_PERIOD = DEFAULT_MIN_PERIOD
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic                 en,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [DATAWIDTH-1:0] cfg_period,
  input  logic [DATAWIDTH-1:0] cfg_high,
  output logic                 cfg_err,
  output logic                 pwm_out,
  output logic                 period_start
);

  localparam logic [DATAWIDTH-1:0] MIN_P = DATAWIDTH'(MIN_PERIOD);
  localparam logic [DATAWIDTH-1:0] ONE   = DATAWIDTH'(1);

  pwm_state_e           state_q;
  logic [DATAWIDTH-1:0] act_period_q;
  logic [DATAWIDTH-1:0] act_high_q;
  logic [DATAWIDTH-1:0] pnd_period_q;
  logic [DATAWIDTH-1:0] pnd_high_q;
  logic                 pnd_flag_q;
  logic [DATAWIDTH-1:0] cnt_q;
  logic                 cfg_err_q;
  logic                 pwm_q;
  logic                 period_start_q;

  logic                 xfer;
  logic                 cfg_bad;
  logic                 wrap;
  logic [DATAWIDTH-1:0] cnt_inc;
  logic [DATAWIDTH-1:0] high_next;

  always_comb begin
    xfer      = cfg_valid && !pnd_flag_q;
    cfg_bad   = (cfg_period < MIN_P);
    wrap      = (cnt_q == act_period_q - ONE);
    cnt_inc   = cnt_q + ONE;
    // High time governing the period that starts at a wrap: a pending
    // configuration takes over from its very first cycle.
    high_next = pnd_flag_q ? pnd_high_q : act_high_q;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q        <= ST_IDLE;
      act_period_q   <= '0;
      act_high_q     <= '0;
      pnd_period_q   <= '0;
      pnd_high_q     <= '0;
      pnd_flag_q     <= 1'b0;
      cnt_q          <= '0;
      cfg_err_q      <= 1'b0;
      pwm_q          <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      cfg_err_q      <= 1'b0;
      period_start_q <= 1'b0;

      // A transfer needs an empty slot and a load needs a full one, so the
      // slot writes below and the pnd_flag clears in the FSM never collide.
      if (xfer) begin
        if (cfg_bad) begin
          cfg_err_q <= 1'b1;
        end else begin
          pnd_period_q <= cfg_period;
          pnd_high_q   <= cfg_high;
          pnd_flag_q   <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          pwm_q <= 1'b0;
          if (en && pnd_flag_q) begin
            act_period_q   <= pnd_period_q;
            act_high_q     <= pnd_high_q;
            pnd_flag_q     <= 1'b0;
            pwm_q          <= (pnd_high_q != '0);
            period_start_q <= 1'b1;
            state_q        <= ST_RUN;
          end else if (en && (act_period_q != '0)) begin
            // Restart with the retained configuration from a full period.
            pwm_q          <= (act_high_q != '0);
            period_start_q <= 1'b1;
            state_q        <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (!en) begin
            cnt_q   <= '0;
            pwm_q   <= 1'b0;
            state_q <= ST_IDLE;
          end else if (wrap) begin
            cnt_q          <= '0;
            period_start_q <= 1'b1;
            pwm_q          <= (high_next != '0);
            if (pnd_flag_q) begin
              act_period_q <= pnd_period_q;
              act_high_q   <= pnd_high_q;
              pnd_flag_q   <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_inc;
            pwm_q <= (cnt_inc < act_high_q);
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cfg_ready    = !pnd_flag_q;
  assign cfg_err      = cfg_err_q;
  assign pwm_out      = pwm_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_signal_gen.sv
module tb_pwm_signal_gen;

  logic        sys_clk    = 1'b0;
  logic        sys_rst    = 1'b1;
  logic        en         = 1'b0;
  logic        cfg_valid  = 1'b0;
  logic [29:0] cfg_period = '0;
  logic [29:0] cfg_high   = '0;
  logic        cfg_ready;
  logic        cfg_err;
  logic        pwm_out;
  logic        period_start;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;
  int ph        = 0;  // expected in-period index of the current cycle

  pwm_signal_gen #(
    .DATAWIDTH (30),
    .MIN_PERIOD(2)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .en          (en),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_high    (cfg_high),
    .cfg_err     (cfg_err),
    .pwm_out     (pwm_out),
    .period_start(period_start)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(negedge sys_clk);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    assert (got === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check n cycles of a p/h waveform starting at phase ph, advancing ph.
  task automatic expect_cycles(input string tag, input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      check({tag, "_pwm"}, 32'(pwm_out), 32'(ph < h));
      check({tag, "_ps"}, 32'(period_start), 32'(ph == 0));
      step();
      ph = (ph + 1) % p;
    end
  endtask

  task automatic offer(input int p, input int h);
    cfg_valid  = 1'b1;
    cfg_period = 30'(p);
    cfg_high   = 30'(h);
  endtask

  initial begin
    // Reset state
    step();
    step();
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_ps", 32'(period_start), 0);
    check("rst_rdy", 32'(cfg_ready), 1);
    check("rst_err", 32'(cfg_err), 0);
    sys_rst = 1'b0;

    // 50/25 start-up: first rise two cycles after the transfer
    en = 1'b1;
    offer(50, 25);
    step();
    cfg_valid = 1'b0;
    check("lat_pwm", 32'(pwm_out), 0);
    check("lat_ps", 32'(period_start), 0);
    check("lat_rdy", 32'(cfg_ready), 0);
    step();
    ph = 0;
    expect_cycles("t1", 50, 25, 100);

    // Mid-period change to 100/10 applies at the next wrap
    expect_cycles("t2a", 50, 25, 10);
    offer(100, 10);
    expect_cycles("t2b", 50, 25, 1);
    cfg_valid = 1'b0;
    check("t2_rdy_lo", 32'(cfg_ready), 0);
    expect_cycles("t2c", 50, 25, 49 - ph);
    check("t2_rdy_lo_end", 32'(cfg_ready), 0);
    expect_cycles("t2d", 50, 25, 1);
    check("t2_rdy_hi", 32'(cfg_ready), 1);
    expect_cycles("t2e", 100, 10, 100);

    // Period below minimum is rejected, output unchanged
    expect_cycles("t3a", 100, 10, 30);
    offer(1, 1);
    expect_cycles("t3b", 100, 10, 1);
    cfg_valid = 1'b0;
    check("t3_err", 32'(cfg_err), 1);
    check("t3_rdy", 32'(cfg_ready), 1);
    expect_cycles("t3c", 100, 10, 1);
    check("t3_err_clr", 32'(cfg_err), 0);
    expect_cycles("t3d", 100, 10, 100 - ph);
    expect_cycles("t3e", 100, 10, 100);

    // Minimum period 2/1 alternates 1,0
    offer(2, 1);
    expect_cycles("t3f", 100, 10, 1);
    cfg_valid = 1'b0;
    expect_cycles("t3g", 100, 10, 99);
    expect_cycles("t3alt", 2, 1, 8);

    // Duty extremes: high=0 constant low, high>period constant high
    offer(50, 0);
    expect_cycles("t4a", 2, 1, 1);
    cfg_valid = 1'b0;
    expect_cycles("t4b", 2, 1, 1);
    expect_cycles("t4zero", 50, 0, 100);
    offer(50, 60);
    expect_cycles("t4c", 50, 0, 1);
    cfg_valid = 1'b0;
    expect_cycles("t4d", 50, 0, 49);
    expect_cycles("t4one", 50, 60, 100);

    // Transfer on the wrap edge: old values run one more full period
    expect_cycles("t5a", 50, 60, 49);
    offer(20, 5);
    expect_cycles("t5b", 50, 60, 1);
    cfg_valid = 1'b0;
    check("t5_rdy", 32'(cfg_ready), 0);
    expect_cycles("t5old", 50, 60, 50);
    expect_cycles("t5new", 20, 5, 40);

    // en drop mid-high, then restart from a full high phase
    expect_cycles("t6a", 20, 5, 2);
    en = 1'b0;
    step();
    check("t6_off_pwm", 32'(pwm_out), 0);
    check("t6_off_ps", 32'(period_start), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t6_idle_pwm", 32'(pwm_out), 0);
    end
    en = 1'b1;
    step();
    ph = 0;
    expect_cycles("t6run", 20, 5, 40);

    // Reset mid-period discards configuration
    expect_cycles("t7a", 20, 5, 7);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check("t7_rst_pwm", 32'(pwm_out), 0);
    check("t7_rst_ps", 32'(period_start), 0);
    check("t7_rst_rdy", 32'(cfg_ready), 1);
    check("t7_rst_err", 32'(cfg_err), 0);
    for (int i = 0; i < 30; i++) begin
      step();
      check("t7_idle_pwm", 32'(pwm_out), 0);
      check("t7_idle_ps", 32'(period_start), 0);
    end

    // Reset also discards a pending configuration
    en = 1'b0;
    offer(10, 3);
    step();
    cfg_valid = 1'b0;
    check("t7_pnd_rdy", 32'(cfg_ready), 0);
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    check("t7_pnd_clr", 32'(cfg_ready), 1);
    en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("t7_nocfg_pwm", 32'(pwm_out), 0);
    end

    // New configuration after reset starts normally
    offer(4, 3);
    step();
    cfg_valid = 1'b0;
    check("t7_lat_pwm", 32'(pwm_out), 0);
    step();
    ph = 0;
    expect_cycles("t7run", 4, 3, 12);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
